// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator for the scrolling-background peripheral
//
// Generates the horizontal/vertical raster for the background pixel
// generators. Every output is a register, and the outputs are aligned with
// each other on the same clock edge.
//
// Ports:
//   clk          in   project clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   1 = run raster, 0 = hold idle
//   polarity     in   0 = syncs active-low, 1 = syncs active-high
//   hsync        out  horizontal sync
//   vsync        out  vertical sync
//   visible      out  current pixel lies in the active area
//   pix_x        out  current column, 0..H_TOTAL-1
//   pix_y        out  current line,   0..V_TOTAL-1
//   line_start   out  one-cycle strobe at pix_x == 0 while running
//   frame_start  out  one-cycle strobe at pix_x == 0, pix_y == 0 while running

module vga_timing_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BACK    = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 29,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          polarity,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Coordinate-width copies of the timing boundaries so every compare is
  // done at the counter width.
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_BEGIN = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEGIN = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  // Two-state controller: IDLE holds the raster parked, RUN advances it.
  // The state doubles as the "running" flag: the first enabled edge out of
  // IDLE presents (0,0) instead of advancing.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Next values of every registered output
  logic [CW-1:0] x_d;
  logic [CW-1:0] y_d;
  logic          visible_d;
  logic          hsync_d;
  logic          vsync_d;
  logic          line_start_d;
  logic          frame_start_d;

  logic          h_in_sync;
  logic          v_in_sync;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable alone decides; a drop of enable always parks
  // the raster so that re-enabling restarts from the top-left corner.
  always_comb begin
    state_d = S_IDLE;
    if (enable) begin
      state_d = S_RUN;
    end
  end

  // Output logic: compute the new coordinates, then derive every flag from
  // those new coordinates so all outputs land on the same edge.
  always_comb begin
    x_d           = '0;
    y_d           = '0;
    visible_d     = 1'b0;
    hsync_d       = ~polarity;
    vsync_d       = ~polarity;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_in_sync     = 1'b0;
    v_in_sync     = 1'b0;

    if (enable) begin
      // Advance only when already running; the start edge keeps (0,0).
      if (state_q == S_RUN) begin
        if (pix_x == H_LAST) begin
          x_d = '0;
          y_d = (pix_y == V_LAST) ? '0 : pix_y + CW'(1);
        end else begin
          x_d = pix_x + CW'(1);
          y_d = pix_y;
        end
      end

      h_in_sync     = (x_d >= H_SYNC_BEGIN) && (x_d < H_SYNC_END);
      v_in_sync     = (y_d >= V_SYNC_BEGIN) && (y_d < V_SYNC_END);
      visible_d     = (x_d < H_VIS_END) && (y_d < V_VIS_END);
      // XNOR: polarity level inside the window, inverse outside.
      hsync_d       = ~(polarity ^ h_in_sync);
      vsync_d       = ~(polarity ^ v_in_sync);
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  // Output registers. Reset leaves syncs at 0 (idle for active-high); the
  // first clocked edge afterwards applies the real polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x       <= '0;
      pix_y       <= '0;
      visible     <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= x_d;
      pix_y       <= y_d;
      visible     <= visible_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
//
// Two instances: a full-size 1024x768 timing for horizontal checks, and a
// reduced raster (32 x 20 clocks, 640-clock frame) for vertical/frame checks.
// Reduced raster: H vis 16, fp 4, sync 6 (x 20..25), bp 6;
//                 V vis 12, fp 2, sync 3 (y 14..16), bp 3.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic polarity;
  logic en_f;

  logic        s_hsync, s_vsync, s_visible, s_line, s_frame;
  logic [10:0] s_x, s_y;
  logic        f_hsync, f_vsync, f_visible, f_line, f_frame;
  logic [10:0] f_x, f_y;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .CW(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .polarity(polarity),
    .hsync(s_hsync), .vsync(s_vsync), .visible(s_visible),
    .pix_x(s_x), .pix_y(s_y), .line_start(s_line), .frame_start(s_frame)
  );

  vga_timing_gen dut_full (
    .clk(clk), .rst_n(rst_n), .enable(en_f), .polarity(1'b1),
    .hsync(f_hsync), .vsync(f_vsync), .visible(f_visible),
    .pix_x(f_x), .pix_y(f_y), .line_start(f_line), .frame_start(f_frame)
  );

  wire [26:0] obs_s = {s_hsync, s_vsync, s_visible, s_line, s_frame, s_x, s_y};
  wire [26:0] obs_f = {f_hsync, f_vsync, f_visible, f_line, f_frame, f_x, f_y};

  function automatic logic [26:0] pk(input logic h, input logic v, input logic vis,
                                     input logic ls, input logic fs,
                                     input logic [10:0] x, input logic [10:0] y);
    return {h, v, vis, ls, fs, x, y};
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; en_f = 1'b0; polarity = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs_s !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL reset_small got=%h exp=%h", obs_s, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
    checks++;
    if (obs_f !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL reset_full got=%h exp=%h", obs_f, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
    rst_n = 1'b1;
    repeat (100) tick();
    checks++;
    if (obs_s !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL idle_hold_small got=%h exp=%h", obs_s, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
    checks++;
    if (obs_f !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL idle_hold_full got=%h exp=%h", obs_f, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
  endtask

  task automatic test_horizontal();
    logic        prev_vis;
    logic [10:0] prev_x;
    logic [10:0] hs_first, hs_last, vis_fall_x, wrap_x, wrap_y;
    logic        wrap_ls, wrap_seen, vs_seen;
    int          hs_cnt;
    en_f = 1'b1;
    tick();
    checks++;
    if (obs_f !== pk(0, 0, 1, 1, 1, 11'd0, 11'd0)) begin
      fails++; $display("FAIL full_start got=%h exp=%h", obs_f, pk(0, 0, 1, 1, 1, 11'd0, 11'd0));
    end
    tick();
    checks++;
    if (obs_f !== pk(0, 0, 1, 0, 0, 11'd1, 11'd0)) begin
      fails++; $display("FAIL full_second got=%h exp=%h", obs_f, pk(0, 0, 1, 0, 0, 11'd1, 11'd0));
    end
    prev_vis = f_visible; prev_x = f_x;
    hs_first = '1; hs_last = '1; vis_fall_x = '1; hs_cnt = 0;
    wrap_x = '1; wrap_y = '1; wrap_ls = 1'b0; wrap_seen = 1'b0; vs_seen = 1'b0;
    for (int c = 0; c < 1345; c++) begin
      tick();
      if (f_vsync) vs_seen = 1'b1;
      if (f_y == 11'd0 && f_hsync) begin
        if (hs_cnt == 0) hs_first = f_x;
        hs_last = f_x;
        hs_cnt++;
      end
      if (prev_vis && !f_visible && vis_fall_x == '1) vis_fall_x = f_x;
      if (prev_x == 11'd1343 && !wrap_seen) begin
        wrap_seen = 1'b1; wrap_x = f_x; wrap_y = f_y; wrap_ls = f_line;
      end
      prev_vis = f_visible; prev_x = f_x;
    end
    checks++;
    if (vis_fall_x !== 11'd1024) begin
      fails++; $display("FAIL vis_fall_x got=%0d exp=1024", vis_fall_x);
    end
    checks++;
    if ({hs_first, hs_last} !== {11'd1048, 11'd1183} || hs_cnt != 136) begin
      fails++; $display("FAIL hsync_window got=%0d..%0d n=%0d exp=1048..1183 n=136", hs_first, hs_last, hs_cnt);
    end
    checks++;
    if ({wrap_seen, wrap_x, wrap_y, wrap_ls, vs_seen} !== {1'b1, 11'd0, 11'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL h_wrap got=seen%b x%0d y%0d ls%b vs%b exp=seen1 x0 y1 ls1 vs0",
                        wrap_seen, wrap_x, wrap_y, wrap_ls, vs_seen);
    end
    en_f = 1'b0;
  endtask

  task automatic test_vertical(input logic pol);
    int          hs_cnt, vs_cnt, vis_cnt, bad_vis, fs_cnt;
    logic [10:0] vs_first, vs_last, vs_rise_x, prev_x, prev_y;
    logic        prev_vs;
    polarity = pol;
    enable = 1'b0;
    tick();
    checks++;
    if (obs_s !== pk(~pol, ~pol, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL v_idle pol=%b got=%h exp=%h", pol, obs_s, pk(~pol, ~pol, 0, 0, 0, 11'd0, 11'd0));
    end
    enable = 1'b1;
    tick();
    checks++;
    if (obs_s !== pk(~pol, ~pol, 1, 1, 1, 11'd0, 11'd0)) begin
      fails++; $display("FAIL v_start pol=%b got=%h exp=%h", pol, obs_s, pk(~pol, ~pol, 1, 1, 1, 11'd0, 11'd0));
    end
    hs_cnt = 0; vs_cnt = 0; vis_cnt = 0; bad_vis = 0; fs_cnt = 0;
    vs_first = '1; vs_last = '1; vs_rise_x = '1; prev_vs = 1'b0;
    prev_x = '0; prev_y = '0;
    for (int c = 0; c < 640; c++) begin
      if (s_hsync === pol) hs_cnt++;
      if (s_vsync === pol) begin
        vs_cnt++;
        if (!prev_vs) begin vs_first = s_y; vs_rise_x = s_x; end
        vs_last = s_y;
      end
      prev_vs = (s_vsync === pol);
      if (s_visible) begin
        vis_cnt++;
        if (s_y >= 11'd12 || s_x >= 11'd16) bad_vis++;
      end
      if (s_frame) fs_cnt++;
      prev_x = s_x; prev_y = s_y;
      tick();
    end
    checks++;
    if (hs_cnt != 120 || vs_cnt != 96) begin
      fails++; $display("FAIL sync_counts pol=%b got=hs%0d vs%0d exp=hs120 vs96", pol, hs_cnt, vs_cnt);
    end
    checks++;
    if ({vs_first, vs_last, vs_rise_x} !== {11'd14, 11'd16, 11'd0}) begin
      fails++; $display("FAIL vsync_lines pol=%b got=%0d..%0d x%0d exp=14..16 x0", pol, vs_first, vs_last, vs_rise_x);
    end
    checks++;
    if (vis_cnt != 192 || bad_vis != 0) begin
      fails++; $display("FAIL visible_area pol=%b got=n%0d bad%0d exp=n192 bad0", pol, vis_cnt, bad_vis);
    end
    checks++;
    if (fs_cnt != 1 || s_frame !== 1'b1 || {prev_y, prev_x, s_y, s_x} !== {11'd19, 11'd31, 11'd0, 11'd0}) begin
      fails++; $display("FAIL frame_wrap pol=%b got=fs%0d/%b %0d,%0d->%0d,%0d exp=fs1/1 31,19->0,0",
                        pol, fs_cnt, s_frame, prev_x, prev_y, s_x, s_y);
    end
  endtask

  task automatic test_drop_enable();
    int budget;
    polarity = 1'b1;
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    budget = 0;
    while (!(s_x == 11'd10 && s_y == 11'd5) && budget < 1000) begin
      tick(); budget++;
    end
    checks++;
    if (budget >= 1000) begin
      fails++; $display("FAIL drop_reach got=timeout exp=pix(10,5)");
    end
    enable = 1'b0;
    tick();
    checks++;
    if (obs_s !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL drop_idle got=%h exp=%h", obs_s, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
    enable = 1'b1;
    tick();
    checks++;
    if (obs_s !== pk(0, 0, 1, 1, 1, 11'd0, 11'd0)) begin
      fails++; $display("FAIL drop_restart got=%h exp=%h", obs_s, pk(0, 0, 1, 1, 1, 11'd0, 11'd0));
    end
    tick();
    checks++;
    if (obs_s !== pk(0, 0, 1, 0, 0, 11'd1, 11'd0)) begin
      fails++; $display("FAIL drop_advance got=%h exp=%h", obs_s, pk(0, 0, 1, 0, 0, 11'd1, 11'd0));
    end
  endtask

  task automatic test_polarity_switch();
    // Raster continues from drop test at x=1, y=0.
    repeat (20) tick();
    checks++;
    if (obs_s !== pk(1, 0, 0, 0, 0, 11'd21, 11'd0)) begin
      fails++; $display("FAIL pol_before got=%h exp=%h", obs_s, pk(1, 0, 0, 0, 0, 11'd21, 11'd0));
    end
    polarity = 1'b0;
    tick();
    checks++;
    if (obs_s !== pk(0, 1, 0, 0, 0, 11'd22, 11'd0)) begin
      fails++; $display("FAIL pol_after got=%h exp=%h", obs_s, pk(0, 1, 0, 0, 0, 11'd22, 11'd0));
    end
  endtask

  task automatic test_async_reset();
    polarity = 1'b1;
    repeat (5) tick();
    en_f = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0) || obs_f !== pk(0, 0, 0, 0, 0, 11'd0, 11'd0)) begin
      fails++; $display("FAIL async_clear got=%h/%h exp=%h", obs_s, obs_f, pk(0, 0, 0, 0, 0, 11'd0, 11'd0));
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (obs_s !== pk(0, 0, 1, 1, 1, 11'd0, 11'd0) || obs_f !== pk(0, 0, 1, 1, 1, 11'd0, 11'd0)) begin
      fails++; $display("FAIL reset_restart got=%h/%h exp=%h", obs_s, obs_f, pk(0, 0, 1, 1, 1, 11'd0, 11'd0));
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical(1'b1);
    test_vertical(1'b0);
    test_drop_enable();
    test_polarity_switch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
